// File: rtl/img_stream_gen_pkg.sv
// Shared types and timing profiles for the image stream generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, default 640x480 timing, small simulation timing
// profile, and a counter-width helper that never returns zero.
package img_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    // 640x480 profile
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 160;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_PRE    = 2;
    localparam int DEF_V_BLANK  = 20;

    // Small profile: 6-cycle lines, 6-line frames, 36 cycles per frame
    localparam int TB_DATA_W   = 8;
    localparam int TB_H_ACTIVE = 4;
    localparam int TB_H_BLANK  = 2;
    localparam int TB_V_ACTIVE = 3;
    localparam int TB_V_PRE    = 1;
    localparam int TB_V_BLANK  = 2;

    // Width needed to hold 0..n-1; a count of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/img_stream_gen_if.sv
// Pixel-stream bundle: upstream ready/valid pixels in, timed video stream out.
// Latency: n/a (wires only).
// Backpressure: s_ready is the only backpressure signal; the video side has none.
// Ports: s_data/s_valid/s_ready (upstream), img_vsync/img_hsync/img_valid/
// img_data (video out), frame_start pulse, underflow_cnt status.
// master = the generator, slave = the side feeding pixels and watching video.
interface img_stream_gen_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              img_vsync;
    logic              img_hsync;
    logic              img_valid;
    logic [DATA_W-1:0] img_data;
    logic              frame_start;
    logic [15:0]       underflow_cnt;

    modport master (
        input  s_data, s_valid,
        output s_ready,
        output img_vsync, img_hsync, img_valid, img_data,
        output frame_start, underflow_cnt
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready,
        input  img_vsync, img_hsync, img_valid, img_data,
        input  frame_start, underflow_cnt
    );

endinterface

// File: rtl/img_stream_gen_timing_cnt.sv
// Horizontal/vertical position counters and region flags for the stream generator.
// Latency: flags are combinational from the registered counters.
// Backpressure: none; counters free-run while run is high and never stall.
// Ports: clk, rst (async, active-high); run (hold at 0 when low), v_clr (clear
// line count on a region change); line_end, h_act, pre_last, act_last,
// blank_last flags; tpg_pix test pattern when IMG_STREAM_TPG_EN is defined.
module img_timing_cnt
    import img_stream_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_PRE    = DEF_V_PRE,
    parameter int V_BLANK  = DEF_V_BLANK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              v_clr,
    output logic              line_end,
    output logic              h_act,
    output logic              pre_last,
    output logic              act_last,
    output logic              blank_last
`ifdef IMG_STREAM_TPG_EN
    ,
    output logic [DATA_W-1:0] tpg_pix
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_PRE + V_ACTIVE + V_BLANK;
    localparam int H_W     = cnt_w(H_TOTAL);
    localparam int V_W     = cnt_w(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_N    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_PRE_LAST = V_W'(V_PRE - 1);
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] V_BLK_LAST = V_W'(V_BLANK - 1);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;

    // v_cnt counts lines within the current region, so it restarts on every
    // region change and the region flags compare against per-region lengths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (v_clr) begin
                v_cnt <= '0;
            end else if (line_end) begin
                v_cnt <= v_cnt + 1'b1;
            end
        end
    end

    assign line_end   = (h_cnt == H_LAST);
    assign h_act      = (h_cnt <  H_ACT_N);
    assign pre_last   = (v_cnt == V_PRE_LAST);
    assign act_last   = (v_cnt == V_ACT_LAST);
    assign blank_last = (v_cnt == V_BLK_LAST);

`ifdef IMG_STREAM_TPG_EN
    logic [DATA_W-1:0] h_lo;
    logic [DATA_W-1:0] v_lo;

    // Counters may be narrower or wider than a pixel: pad or take low bits.
    if (H_W >= DATA_W) begin : g_h_slice
        assign h_lo = h_cnt[DATA_W-1:0];
    end else begin : g_h_pad
        assign h_lo = {{(DATA_W-H_W){1'b0}}, h_cnt};
    end

    if (V_W >= DATA_W) begin : g_v_slice
        assign v_lo = v_cnt[DATA_W-1:0];
    end else begin : g_v_pad
        assign v_lo = {{(DATA_W-V_W){1'b0}}, v_cnt};
    end

    assign tpg_pix = h_lo ^ v_lo;
`endif

endmodule

// File: rtl/img_stream_gen.sv
// Pixel stream source: pulls upstream pixels and emits them with vsync/hsync timing.
// Latency: 1 cycle from the s_ready cycle to img_valid/img_data.
// Backpressure: none downstream; upstream stalls show up as zero pixels and
//   bump underflow_cnt, line/frame timing never stretches.
// Ports: clk, rst (async active-high), enable (frames run while high),
//   bus (img_stream_gen_if.master: s_* upstream, img_* video, frame_start,
//   underflow_cnt). Optional IMG_STREAM_TPG_EN adds tpg_sel, which replaces
//   upstream data with an h^v pattern for a whole frame.
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_PRE    = DEF_V_PRE,
    parameter int V_BLANK  = DEF_V_BLANK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
`ifdef IMG_STREAM_TPG_EN
    input  logic               tpg_sel,
`endif
    img_stream_gen_if.master   bus
);

    state_t state;
    state_t state_nxt;

    logic run;
    logic v_clr;
    logic line_end;
    logic h_act;
    logic pre_last;
    logic act_last;
    logic blank_last;

    logic              act_win;
    logic              rdy;
    logic              vsync_d;
    logic              fs_d;
    logic              uf_inc;
    logic [DATA_W-1:0] data_d;

    logic              tpg_frame;
    logic [DATA_W-1:0] tpg_pix;

    logic              vsync_q;
    logic              hsync_q;
    logic              fs_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       uf_q;

    assign run   = (state != ST_IDLE);
    assign v_clr = (state_nxt != state);

    img_timing_cnt #(
        .DATA_W   (DATA_W),
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_PRE    (V_PRE),
        .V_BLANK  (V_BLANK)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .v_clr      (v_clr),
        .line_end   (line_end),
        .h_act      (h_act),
        .pre_last   (pre_last),
        .act_last   (act_last),
        .blank_last (blank_last)
`ifdef IMG_STREAM_TPG_EN
        ,
        .tpg_pix    (tpg_pix)
`endif
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: every region ends on a line boundary, so a frame already
    // started always runs to the end of BLANK even if enable drops.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (enable) state_nxt = ST_PRE;
            ST_PRE:    if (line_end && pre_last) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (line_end && act_last) state_nxt = ST_BLANK;
            ST_BLANK:  if (line_end && blank_last) state_nxt = enable ? ST_PRE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. vsync/frame_start look at the next state so they are
    // registered in step with the state itself; hsync/data look at the
    // current cycle's window and so trail s_ready by one cycle.
    always_comb begin
        act_win = (state == ST_ACTIVE) && h_act;
        rdy     = act_win && !tpg_frame;
        vsync_d = (state_nxt == ST_PRE) || (state_nxt == ST_ACTIVE);
        fs_d    = (state != ST_PRE) && (state_nxt == ST_PRE);
        uf_inc  = rdy && !bus.s_valid;
        data_d  = '0;
        if (act_win) begin
            if (tpg_frame) begin
                data_d = tpg_pix;
            end else if (bus.s_valid) begin
                data_d = bus.s_data;
            end
        end
    end

`ifdef IMG_STREAM_TPG_EN
    // Pattern choice is latched on PRE entry so a frame is never mixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpg_frame <= 1'b0;
        end else if (fs_d) begin
            tpg_frame <= tpg_sel;
        end
    end
`else
    assign tpg_frame = 1'b0;
    assign tpg_pix   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            fs_q    <= 1'b0;
            data_q  <= '0;
            uf_q    <= '0;
        end else begin
            vsync_q <= vsync_d;
            hsync_q <= act_win;
            fs_q    <= fs_d;
            data_q  <= data_d;
            if (uf_inc && (uf_q != 16'hFFFF)) begin
                uf_q <= uf_q + 16'd1;
            end
        end
    end

    assign bus.s_ready       = rdy;
    assign bus.img_vsync     = vsync_q;
    assign bus.img_hsync     = hsync_q;
    assign bus.img_valid     = hsync_q;
    assign bus.img_data      = data_q;
    assign bus.frame_start   = fs_q;
    assign bus.underflow_cnt = uf_q;

endmodule
